// File: rtl/od_pkg.sv
// od_pkg: shared FSM state type and default sizes for od_sequencer.
// Also holds the saturating fill-count helper.
package od_pkg;

    localparam int OD_ADDR_W = 8;
    localparam int OD_DATA_W = 16;
    localparam int OD_WIN    = 8;
    localparam int OD_CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_START,
        ST_COMPUTE
    } od_state_t;

    function automatic logic [OD_CNT_W-1:0] sat_inc(
        input logic [OD_CNT_W-1:0] v,
        input logic [OD_CNT_W-1:0] lim
    );
        return (v >= lim) ? lim : v + OD_CNT_W'(1);
    endfunction

endpackage

// File: rtl/od_req_edge.sv
// od_req_edge: synchronizes new_number and emits one pulse per rising edge.
// OD_SEQUENCER_DEBOUNCE_EN adds a DEB_CYC stability filter before the edge detect.
module od_req_edge
    import od_pkg::*;
`ifdef OD_SEQUENCER_DEBOUNCE_EN
#(
    parameter int DEB_CYC = 4
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    output logic o_req
);

    logic r_sync1;
    logic r_sync2;
    logic r_prime1;
    logic r_prime2;
    logic r_armed;
    logic r_prev;
    logic w_level;

    // two-flop synchronizer plus a chain marking when r_sync2 holds a real sample
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_prime1 <= 1'b0;
            r_prime2 <= 1'b0;
        end else begin
            r_sync1  <= i_level;
            r_sync2  <= r_sync1;
            r_prime1 <= 1'b1;
            r_prime2 <= r_prime1;
        end
    end

`ifdef OD_SEQUENCER_DEBOUNCE_EN
    localparam logic [OD_CNT_W-1:0] LP_DEB_LAST = OD_CNT_W'(DEB_CYC - 1);

    logic [OD_CNT_W-1:0] r_deb_cnt;
    logic                r_deb_lvl;

    // accept a new level only after DEB_CYC consecutive cycles of it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb_cnt <= '0;
            r_deb_lvl <= 1'b0;
        end else if (r_sync2 == r_deb_lvl) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == LP_DEB_LAST) begin
            r_deb_cnt <= '0;
            r_deb_lvl <= r_sync2;
        end else begin
            r_deb_cnt <= r_deb_cnt + OD_CNT_W'(1);
        end
    end

    assign w_level = r_deb_lvl;
`else
    assign w_level = r_sync2;
`endif

    // arm only after a genuine low, so a level held through reset is no edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            if (r_prime2 && !r_sync2) r_armed <= 1'b1;
            r_prev <= w_level;
        end
    end

    assign o_req = r_armed & w_level & ~r_prev;

endmodule

// File: rtl/od_sequencer.sv
// od_sequencer: fetches one sample per request, runs the outlier core, qualifies flag.
// Optional debounce on new_number: define OD_SEQUENCER_DEBOUNCE_EN.
module od_sequencer
    import od_pkg::*;
#(
    parameter int ADDR_W  = OD_ADDR_W,
    parameter int DATA_W  = OD_DATA_W,
    parameter int WIN     = OD_WIN,
    parameter int DEB_CYC = 4
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              new_number,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic              core_start,
    output logic [DATA_W-1:0] core_sample,
    input  logic              core_done,
    input  logic              core_outlier,
    output logic              flag,
    output logic              busy,
    output logic              warm,
    output logic              overrun
);

    localparam logic [OD_CNT_W-1:0] LP_WIN = OD_CNT_W'(WIN);

    if (WIN < 2 || WIN > 255 || DEB_CYC < 1 || DEB_CYC > 255) begin : g_param_check
        $error("od_sequencer: WIN or DEB_CYC out of range");
    end

    od_state_t           r_state;
    od_state_t           w_next;
    logic                w_req;
    logic                w_done;
    logic [OD_CNT_W-1:0] r_fill;
    logic [OD_CNT_W-1:0] w_fill_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_sample;
    logic                r_flag;
    logic                r_overrun;

`ifdef OD_SEQUENCER_DEBOUNCE_EN
    od_req_edge #(
        .DEB_CYC (DEB_CYC)
    ) u_req (
        .clk     (clk),
        .reset   (reset),
        .i_level (new_number),
        .o_req   (w_req)
    );
`else
    od_req_edge u_req (
        .clk     (clk),
        .reset   (reset),
        .i_level (new_number),
        .o_req   (w_req)
    );
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // next state and the one-cycle strobes
    always_comb begin
        w_next     = r_state;
        rd_en      = 1'b0;
        core_start = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                rd_en  = 1'b1;
                w_next = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (rd_valid) w_next = ST_START;
            end
            ST_START: begin
                core_start = 1'b1;
                w_next     = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (core_done) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_fill_next = sat_inc(r_fill, LP_WIN);

    // per-transaction bookkeeping: sample, address, fill count, verdict, overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample  <= '0;
            r_addr    <= '0;
            r_fill    <= '0;
            r_flag    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == ST_WAIT_DATA && rd_valid) r_sample <= rd_data;
            if (w_done) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_fill <= w_fill_next;
                if (w_fill_next == LP_WIN) r_flag <= core_outlier;
            end
            if (w_req && r_state != ST_IDLE) r_overrun <= 1'b1;
        end
    end

    assign rd_addr     = r_addr;
    assign core_sample = r_sample;
    assign flag        = r_flag;
    assign overrun     = r_overrun;
    assign busy        = (r_state != ST_IDLE);
    assign warm        = (r_fill == LP_WIN);

endmodule

// File: doc/od_sequencer.md
OD_SEQUENCER -- requirements
Module: od_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, sample-memory address width.
REQ-002 Parameter DATA_W, default 16, sample width.
REQ-003 Parameter WIN, default 8, window length before flag is qualified (2..255).
REQ-004 Parameter DEB_CYC, default 4, debounce stability cycles (1..255).
REQ-005 Port clk  in  1  single clock; all logic on rising edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port new_number  in  1  asynchronous request level; each rising edge requests one sample.
REQ-008 Port rd_en  out  1  one-cycle sample-memory read strobe.
REQ-009 Port rd_addr  out  ADDR_W  read address, valid while rd_en high.
REQ-010 Port rd_data  in  DATA_W  read data, valid with rd_valid.
REQ-011 Port rd_valid  in  1  read-data qualifier.
REQ-012 Port core_start  out  1  one-cycle start pulse to outlier core.
REQ-013 Port core_sample  out  DATA_W  sample to core, held stable from core_start until core_done.
REQ-014 Port core_done  in  1  core completion pulse.
REQ-015 Port core_outlier  in  1  core verdict, valid with core_done.
REQ-016 Port flag  out  1  registered outlier verdict.
REQ-017 Port busy  out  1  high in any state other than IDLE.
REQ-018 Port warm  out  1  high once WIN samples have completed.
REQ-019 Port overrun  out  1  sticky: request arrived while busy.

Function
REQ-020 new_number shall pass a 2-flop synchronizer; a request is a synchronized 0->1 transition.
REQ-021 FSM states IDLE, FETCH, WAIT_DATA, START, COMPUTE; one state per cycle minimum.
REQ-022 IDLE->FETCH on request; FETCH asserts rd_en for exactly one cycle, then WAIT_DATA.
REQ-023 WAIT_DATA shall ignore rd_valid in the FETCH cycle; on rd_valid capture rd_data into core_sample, go START.
REQ-024 START asserts core_start one cycle, then COMPUTE; COMPUTE waits for core_done.
REQ-025 On core_done: fill count increments (saturating at WIN); rd_addr increments; return to IDLE.
REQ-026 rd_addr shall wrap from 2^ADDR_W-1 to 0.
REQ-027 flag shall load core_outlier on core_done only when fill count (post-increment) equals WIN; otherwise flag holds 0.
REQ-028 flag shall hold its value until the next qualifying core_done.
REQ-029 warm shall rise in the cycle after the WIN-th core_done and remain high.
REQ-030 A request while busy shall be dropped and set overrun; a request in the cycle FSM returns to IDLE is also dropped.
REQ-031 core_done/rd_valid outside their waiting states shall be ignored.
REQ-032 Request-to-rd_en latency: 3 cycles after new_number rises (sync 2 + FETCH), without debounce.

Reset
REQ-033 Reset shall force IDLE; rd_en, core_start, flag, busy, warm, overrun = 0; rd_addr = 0; fill count = 0; core_sample = 0; synchronizer flops = 0.
REQ-034 Reset mid-operation shall abandon the transaction with no flag update; a new_number held high through reset release shall not generate a request.

Configuration
REQ-035 Macro OD_SEQUENCER_DEBOUNCE_EN defined: synchronized new_number shall be stable DEB_CYC consecutive cycles before its level is accepted; edge detected on the debounced level; latency REQ-032 grows by DEB_CYC.
REQ-036 Macro undefined: no debounce logic; edge on synchronized level directly.

Structure
REQ-037 Package od_pkg shall hold the FSM state enum and default ADDR_W/DATA_W/WIN constants.
REQ-038 Sub-module od_req_edge shall contain synchronizer, optional debounce and rising-edge detect.

Verification
REQ-039 Reset then one new_number pulse (300 cycles), rd_valid 2 cycles after rd_en, rd_data=0x1234 -> rd_addr=0, core_sample=0x1234, one core_start, busy falls after core_done.
REQ-040 10 requests, WIN=8, core_outlier=1 each -> flag 0 through 7th, flag 1 after 8th, warm rises after 8th, rd_addr=10.
REQ-041 Second new_number edge during COMPUTE -> overrun=1, no extra rd_en, rd_addr unchanged by dropped request.
REQ-042 256 requests, ADDR_W=8 -> rd_addr 255 then 0.
REQ-043 reset asserted in COMPUTE with new_number high -> all outputs at reset values, no request after release until new_number falls and rises.
REQ-044 OD_SEQUENCER_DEBOUNCE_EN, DEB_CYC=4: 2-cycle glitch on new_number -> no rd_en; 10-cycle pulse -> one rd_en 7 cycles after rise.
